uart_parity_unit: RTL and testbench
===================================

# uart_parity_unit

Parametrised parity engine for the UART datapath, sharing one configuration between a TX parity generator and an RX bit-serial parity checker. TX side latches a parallel word on the load strobe, masks it to the runtime data length, and holds the computed parity bit for the serializer. RX side accumulates sampled data bits frame by frame, compares against the sampled parity bit, and flags mismatches. A saturating error counter is included. Sits between the UART FSM/serializer and the RX sampler.

## Interface
- DATA_WIDTH, 8, maximum data bits per frame (5..16)
- LEN_W, $clog2(DATA_WIDTH+1), width of DATA_LEN
- ERR_CNT_W, 8, width of the saturating error counter

- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- PAR_EN  in  1  parity enabled for the frame
- PAR_TYP  in  2  00 even, 01 odd, 10 mark (1), 11 space (0)
- DATA_LEN  in  LEN_W  valid data bits, 1..DATA_WIDTH; 0 or >DATA_WIDTH means DATA_WIDTH
- P_DATA  in  DATA_WIDTH  TX parallel word, LSB first
- DATA_valid  in  1  TX load strobe
- Busy  in  1  serializer busy; blocks loads
- par_bit  out  1  TX parity bit
- par_en_out  out  1  latched PAR_EN of the current TX word
- rx_frame_start  in  1  RX start bit detected; clears the accumulator
- rx_bit_en  in  1  rx_bit carries a sampled data bit
- rx_par_en  in  1  rx_bit carries the sampled parity bit
- rx_bit  in  1  sampled RX bit
- par_chk_done  out  1  one-cycle pulse, RX frame check finished
- par_err  out  1  one-cycle pulse with par_chk_done on mismatch
- err_cnt  out  ERR_CNT_W  saturating count of par_err pulses
- err_clr  in  1  synchronous clear of err_cnt

## Operation
- Parity function over the masked word: even = XOR of the bits; odd = inverted XOR; mark = 1; space = 0.
- Mask: bits at index >= effective length are forced to 0.
- TX accept = DATA_valid & !Busy.
  - On accept, register par_bit from the live P_DATA/PAR_TYP/DATA_LEN/PAR_EN.
  - Register par_en_out = PAR_EN.
  - If PAR_EN = 0, par_bit = 0.
  - DATA_valid while Busy is ignored and par_bit holds.
- RX FSM states: IDLE, DATA, PARITY.
  - rx_frame_start in any state: load PAR_EN/PAR_TYP/effective length into config registers, clear accumulator and bit counter, go to DATA. This has highest priority.
  - DATA, on rx_bit_en: acc ^= rx_bit, count++. When count reaches the length:
    - if the latched PAR_EN = 1, go to PARITY;
    - otherwise pulse par_chk_done next cycle with par_err = 0 and return to IDLE.
  - PARITY, on rx_par_en: expected = parity(acc, latched type). Pulse par_chk_done; pulse par_err if rx_bit != expected. Return to IDLE.
  - rx_bit_en outside DATA is ignored. rx_par_en outside PARITY is ignored. Both asserted together is treated as rx_bit_en only.
- err_cnt increments on par_err and saturates at all-ones. err_clr wins over a simultaneous increment.
- Config inputs change freely mid-frame. Only the values latched at accept/frame start are used.

## Timing
- Reset values: par_bit 0, par_en_out 0, par_chk_done 0, par_err 0, err_cnt 0, FSM IDLE, accumulator and counter 0.
- Reset asserted mid-frame aborts the check; no pulse is issued.
- TX latency: par_bit is valid on the first rising edge after the accept cycle, and stable until the next accept.
- RX latency: par_chk_done/par_err are registered, high the cycle after the rx_par_en cycle (or after the last data bit when parity is disabled).
- rx_frame_start on the same cycle as rx_par_en: the restart wins, and the old frame produces no pulse.
- par_err is never high without par_chk_done.

## Structure
- Shared package holds:
  - PAR_TYP encodings (PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE);
  - the RX FSM state enum;
  - a parity function (word, length, type) used by both sides.
- One natural sub-module: uart_par_rx_chk (RX FSM, accumulator, counter). The TX generator and error counter stay in the top.

## Test plan
- TX even/odd, DATA_LEN 8: load 8'b11001100 even -> par_bit 0; odd -> 1; 8'b01001100 even -> 1; 8'b10001100 odd -> 0.
- TX length/mask: 8'b10001100 even, DATA_LEN 5 -> 0 (low 5 bits 01100); DATA_LEN 0 -> 1; mark -> 1, space -> 0; PAR_EN 0 -> par_bit 0, par_en_out 0.
- TX Busy: accept 0xCC even (par_bit 0), then DATA_valid with 0x4C while Busy=1 -> par_bit stays 0; with Busy=0 -> 1.
- RX check: frame start, even, len 8, bits of 0xA5 LSB first, parity bit 0 -> par_chk_done pulse, par_err 0; same frame with parity bit 1 -> par_err pulse, err_cnt 1.
- RX boundaries:
  - rx_frame_start after 3 data bits restarts the count, and the correct parity is then accepted;
  - rx_par_en during DATA is ignored;
  - PAR_EN 0 frame -> done after 8th bit, no error.
- err_cnt: force 300 mismatches with ERR_CNT_W 8 -> saturates at 255; err_clr together with par_err -> 0; RST low mid-frame -> all outputs at reset values, no pulse.

Source files
------------

// File: rtl/uart_parity_unit_pkg.sv
// Shared definitions for the UART parity engine.
// Holds the parity-type encodings, the RX checker state enum and the
// parity function used by both the TX generator and the RX checker.
package uart_parity_unit_pkg;

  // Widest word the parity function handles; callers zero-extend into it.
  localparam int PAR_MAX_W = 16;
  localparam int PAR_LEN_W = 5;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2
  } rx_state_t;

  // Bits at index >= len do not take part in the XOR.
  function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] word,
                                       input logic [PAR_LEN_W-1:0] len,
                                       input logic [1:0]           typ);
    logic x;
    logic res;
    x = 1'b0;
    for (int i = 0; i < PAR_MAX_W; i++) begin
      if (i < int'(len)) x = x ^ word[i];
    end
    case (typ)
      PAR_EVEN: res = x;
      PAR_ODD:  res = ~x;
      PAR_MARK: res = 1'b1;
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/uart_par_rx_chk.sv
// Bit-serial RX parity checker.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   frame_start         restart: latch config, clear accumulator/counter
//   bit_en, par_in      rx_bit is a data bit / the parity bit
//   rx_bit              sampled RX bit
//   cfg_par_en/typ/len  live config (len already resolved to 1..DATA_WIDTH)
//   chk_done, chk_err   registered one-cycle result pulses
//
// state     | meaning
// ----------+-----------------------------------------------
// RX_IDLE   | no frame in progress, data/parity bits ignored
// RX_DATA   | accumulating data bits until count == length
// RX_PARITY | waiting for the sampled parity bit
module uart_par_rx_chk
  import uart_parity_unit_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             bit_en,
  input  logic             par_in,
  input  logic             rx_bit,
  input  logic             cfg_par_en,
  input  logic [1:0]       cfg_par_typ,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             chk_done,
  output logic             chk_err
);

  rx_state_t        state_q, state_d;
  logic             acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] cnt_inc;
  logic             en_q, en_d;
  logic [1:0]       typ_q, typ_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             done_d, err_d;
  logic             exp_par;

  assign cnt_inc = cnt_q + LEN_W'(1);
  // The accumulator already holds the XOR of the data bits, so the parity
  // function only needs to look at that single bit.
  assign exp_par = calc_parity({{(PAR_MAX_W-1){1'b0}}, acc_q}, PAR_LEN_W'(1), typ_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RX_IDLE;
      acc_q    <= 1'b0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      typ_q    <= PAR_EVEN;
      len_q    <= '0;
      chk_done <= 1'b0;
      chk_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      typ_q    <= typ_d;
      len_q    <= len_d;
      chk_done <= done_d;
      chk_err  <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    typ_d   = typ_q;
    len_d   = len_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (frame_start) begin
      // Restart beats everything, including a parity bit in the same cycle.
      en_d    = cfg_par_en;
      typ_d   = cfg_par_typ;
      len_d   = cfg_len;
      acc_d   = 1'b0;
      cnt_d   = '0;
      state_d = RX_DATA;
    end else begin
      case (state_q)
        RX_DATA: begin
          if (bit_en) begin
            acc_d = acc_q ^ rx_bit;
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) begin
              if (en_q) begin
                state_d = RX_PARITY;
              end else begin
                done_d  = 1'b1;
                state_d = RX_IDLE;
              end
            end
          end
        end
        RX_PARITY: begin
          // A data strobe alongside the parity strobe takes precedence,
          // and data bits are meaningless here, so the pair does nothing.
          if (par_in && !bit_en) begin
            done_d  = 1'b1;
            err_d   = (rx_bit != exp_par);
            state_d = RX_IDLE;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_parity_unit.sv
// UART parity engine: TX parity generator, RX parity checker and a
// saturating parity-error counter sharing one runtime configuration.
// Ports:
//   CLK, RST               clock, async active-low reset
//   PAR_EN, PAR_TYP        parity enable / type (even, odd, mark, space)
//   DATA_LEN               data bits per frame; 0 or too large = DATA_WIDTH
//   P_DATA, DATA_valid     TX word and load strobe (ignored while Busy)
//   par_bit, par_en_out    TX parity bit and its latched enable
//   rx_frame_start, rx_bit_en, rx_par_en, rx_bit   RX sampler interface
//   par_chk_done, par_err  RX check result pulses
//   err_cnt, err_clr       saturating error count and its clear
module uart_parity_unit
  import uart_parity_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = $clog2(DATA_WIDTH + 1),
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_TYP,
  input  logic [LEN_W-1:0]      DATA_LEN,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_valid,
  input  logic                  Busy,
  output logic                  par_bit,
  output logic                  par_en_out,
  input  logic                  rx_frame_start,
  input  logic                  rx_bit_en,
  input  logic                  rx_par_en,
  input  logic                  rx_bit,
  output logic                  par_chk_done,
  output logic                  par_err,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  input  logic                  err_clr
);

  logic [LEN_W-1:0] eff_len;
  logic             tx_accept;
  logic             tx_par;

  assign eff_len = ((DATA_LEN == '0) || (DATA_LEN > LEN_W'(DATA_WIDTH)))
                   ? LEN_W'(DATA_WIDTH) : DATA_LEN;

  assign tx_accept = DATA_valid && !Busy;
  assign tx_par    = calc_parity(PAR_MAX_W'(P_DATA), PAR_LEN_W'(eff_len), PAR_TYP);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_bit    <= 1'b0;
      par_en_out <= 1'b0;
    end else if (tx_accept) begin
      par_bit    <= PAR_EN ? tx_par : 1'b0;
      par_en_out <= PAR_EN;
    end
  end

  uart_par_rx_chk #(
    .LEN_W (LEN_W)
  ) u_rx_chk (
    .clk         (CLK),
    .rst_n       (RST),
    .frame_start (rx_frame_start),
    .bit_en      (rx_bit_en),
    .par_in      (rx_par_en),
    .rx_bit      (rx_bit),
    .cfg_par_en  (PAR_EN),
    .cfg_par_typ (PAR_TYP),
    .cfg_len     (eff_len),
    .chk_done    (par_chk_done),
    .chk_err     (par_err)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (par_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_parity_unit.sv
module tb_uart_parity_unit;

  localparam int DW = 8;
  localparam int LW = 4;
  localparam int EW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          PAR_EN = 1'b0;
  logic [1:0]    PAR_TYP = 2'b00;
  logic [LW-1:0] DATA_LEN = '0;
  logic [DW-1:0] P_DATA = '0;
  logic          DATA_valid = 1'b0;
  logic          Busy = 1'b0;
  logic          par_bit;
  logic          par_en_out;
  logic          rx_frame_start = 1'b0;
  logic          rx_bit_en = 1'b0;
  logic          rx_par_en = 1'b0;
  logic          rx_bit = 1'b0;
  logic          par_chk_done;
  logic          par_err;
  logic [EW-1:0] err_cnt;
  logic          err_clr = 1'b0;

  uart_parity_unit #(.DATA_WIDTH(DW), .LEN_W(LW), .ERR_CNT_W(EW)) dut (
    .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .DATA_LEN(DATA_LEN),
    .P_DATA(P_DATA), .DATA_valid(DATA_valid), .Busy(Busy), .par_bit(par_bit),
    .par_en_out(par_en_out), .rx_frame_start(rx_frame_start), .rx_bit_en(rx_bit_en),
    .rx_par_en(rx_par_en), .rx_bit(rx_bit), .par_chk_done(par_chk_done),
    .par_err(par_err), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0] tx_q[$];
  logic       sb_q[$];
  logic [1:0] tx_hold = 2'b00;
  logic       m_acc   = 1'b0;
  logic [1:0] m_typ   = 2'b00;
  int         m_cnt   = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic tx_load(input logic [7:0] d, input logic [1:0] typ, input logic [3:0] len,
                         input logic en, input logic busy, input logic exp_bit, input string tag);
    P_DATA = d; PAR_TYP = typ; DATA_LEN = len; PAR_EN = en; Busy = busy; DATA_valid = 1'b1;
    if (!busy) tx_q.push_back({en, exp_bit});
    @(negedge CLK);
    DATA_valid = 1'b0; Busy = 1'b0;
    P_DATA = ~d; PAR_TYP = typ ^ 2'b01; PAR_EN = ~en;
    if (tx_q.size() > 0) tx_hold = tx_q.pop_front();
    check({tag, "_bit"}, 32'(par_bit), 32'(tx_hold[0]));
    check({tag, "_en"}, 32'(par_en_out), 32'(tx_hold[1]));
    @(negedge CLK);
    check({tag, "_hold"}, 32'(par_bit), 32'(tx_hold[0]));
  endtask

  task automatic start_frame(input logic en, input logic [1:0] typ, input logic [3:0] len);
    rx_frame_start = 1'b1; PAR_EN = en; PAR_TYP = typ; DATA_LEN = len;
    m_acc = 1'b0; m_typ = typ;
    @(negedge CLK);
    rx_frame_start = 1'b0; PAR_EN = ~en; PAR_TYP = ~typ; DATA_LEN = 4'd3;
  endtask

  task automatic send_bits(input logic [15:0] word, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      rx_bit_en = 1'b1; rx_bit = word[i];
      m_acc = m_acc ^ word[i];
      @(negedge CLK);
      rx_bit_en = 1'b0; rx_bit = 1'b0;
    end
  endtask

  task automatic send_parity(input logic pb);
    logic exp;
    exp = (m_typ == 2'b00) ? m_acc : (m_typ == 2'b01) ? ~m_acc : (m_typ == 2'b10);
    sb_q.push_back(pb !== exp);
    rx_par_en = 1'b1; rx_bit = pb;
    @(negedge CLK);
    rx_par_en = 1'b0; rx_bit = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    int  k;
    logic e;
    k = 0;
    while (par_chk_done !== 1'b1 && k < 8) begin
      @(negedge CLK);
      k++;
    end
    check({tag, "_done"}, 32'(par_chk_done), 32'd1);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 1'b0;
    check({tag, "_err"}, 32'(par_err), 32'(e));
    if (e && m_cnt != 255) m_cnt++;
    @(negedge CLK);
    check({tag, "_pulse"}, 32'({par_chk_done, par_err}), 32'd0);
    check({tag, "_cnt"}, 32'(err_cnt), 32'(m_cnt));
  endtask

  initial begin
    @(negedge CLK);
    @(negedge CLK);
    check("rst_par_bit", 32'(par_bit), 32'd0);
    check("rst_par_en_out", 32'(par_en_out), 32'd0);
    check("rst_done_err", 32'({par_chk_done, par_err}), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    RST = 1'b1;
    @(negedge CLK);

    // TX parity
    tx_load(8'hCC, 2'b00, 4'd8, 1'b1, 1'b0, 1'b0, "tx_cc_even");
    tx_load(8'hCC, 2'b01, 4'd8, 1'b1, 1'b0, 1'b1, "tx_cc_odd");
    tx_load(8'h4C, 2'b00, 4'd8, 1'b1, 1'b0, 1'b1, "tx_4c_even");
    tx_load(8'h8C, 2'b01, 4'd8, 1'b1, 1'b0, 1'b0, "tx_8c_odd");
    tx_load(8'h8C, 2'b00, 4'd5, 1'b1, 1'b0, 1'b0, "tx_len5");
    tx_load(8'h8C, 2'b00, 4'd0, 1'b1, 1'b0, 1'b1, "tx_len0");
    tx_load(8'h8C, 2'b00, 4'd12, 1'b1, 1'b0, 1'b1, "tx_len12");
    tx_load(8'h00, 2'b10, 4'd8, 1'b1, 1'b0, 1'b1, "tx_mark");
    tx_load(8'hFF, 2'b11, 4'd8, 1'b1, 1'b0, 1'b0, "tx_space");
    tx_load(8'h4C, 2'b00, 4'd8, 1'b0, 1'b0, 1'b0, "tx_par_off");
    tx_load(8'hCC, 2'b00, 4'd8, 1'b1, 1'b0, 1'b0, "tx_busy_pre");
    tx_load(8'h4C, 2'b00, 4'd8, 1'b1, 1'b1, 1'b0, "tx_busy_blk");
    tx_load(8'h4C, 2'b00, 4'd8, 1'b1, 1'b0, 1'b1, "tx_busy_rel");

    // RX basic check, 0xA5 even
    start_frame(1'b1, 2'b00, 4'd8);
    send_bits(16'h00A5, 0, 8);
    send_parity(1'b0);
    expect_done("rx_a5_ok");
    start_frame(1'b1, 2'b00, 4'd8);
    send_bits(16'h00A5, 0, 8);
    send_parity(1'b1);
    expect_done("rx_a5_bad");

    // Odd parity, short length
    start_frame(1'b1, 2'b01, 4'd5);
    send_bits(16'h0007, 0, 5);
    send_parity(1'b0);
    expect_done("rx_odd_len5");

    // Restart after 3 bits
    start_frame(1'b1, 2'b00, 4'd8);
    send_bits(16'h00FF, 0, 3);
    start_frame(1'b1, 2'b00, 4'd8);
    send_bits(16'h00A5, 0, 8);
    send_parity(1'b0);
    expect_done("rx_restart");

    // rx_par_en during DATA ignored
    start_frame(1'b1, 2'b00, 4'd8);
    send_bits(16'h00A5, 0, 4);
    rx_par_en = 1'b1; rx_bit = 1'b1;
    @(negedge CLK);
    rx_par_en = 1'b0; rx_bit = 1'b0;
    @(negedge CLK);
    check("rx_par_in_data", 32'(par_chk_done), 32'd0);
    send_bits(16'h00A5, 4, 4);
    send_parity(1'b0);
    expect_done("rx_par_ignored");

    // Parity disabled
    start_frame(1'b0, 2'b00, 4'd8);
    send_bits(16'h00A5, 0, 7);
    check("rx_noparity_early", 32'(par_chk_done), 32'd0);
    send_bits(16'h00A5, 7, 1);
    sb_q.push_back(1'b0);
    expect_done("rx_noparity");

    // Restart coinciding with parity bit
    start_frame(1'b1, 2'b00, 4'd8);
    send_bits(16'h00A5, 0, 8);
    rx_frame_start = 1'b1; rx_par_en = 1'b1; rx_bit = 1'b1;
    PAR_EN = 1'b1; PAR_TYP = 2'b00; DATA_LEN = 4'd8;
    m_acc = 1'b0; m_typ = 2'b00;
    @(negedge CLK);
    rx_frame_start = 1'b0; rx_par_en = 1'b0; rx_bit = 1'b0;
    check("rx_restart_vs_par", 32'(par_chk_done), 32'd0);
    send_bits(16'h00A5, 0, 8);
    send_parity(1'b0);
    expect_done("rx_after_restart");

    // Saturation: 300 forced mismatches
    for (int f = 0; f < 300; f++) begin
      start_frame(1'b1, 2'b00, 4'd1);
      send_bits(16'h0000, 0, 1);
      send_parity(1'b1);
      expect_done("rx_sat");
    end
    check("err_cnt_sat", 32'(err_cnt), 32'd255);

    // err_clr together with par_err
    start_frame(1'b1, 2'b00, 4'd1);
    send_bits(16'h0000, 0, 1);
    send_parity(1'b1);
    check("clr_done", 32'(par_chk_done), 32'd1);
    check("clr_err", 32'(par_err), 32'(sb_q.pop_front()));
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    m_cnt = 0;
    check("clr_wins", 32'(err_cnt), 32'd0);

    // Reset mid-frame
    tx_load(8'h4C, 2'b00, 4'd8, 1'b1, 1'b0, 1'b1, "tx_pre_rst");
    start_frame(1'b1, 2'b00, 4'd1);
    send_bits(16'h0000, 0, 1);
    send_parity(1'b1);
    expect_done("rx_pre_rst");
    start_frame(1'b1, 2'b00, 4'd8);
    send_bits(16'h00A5, 0, 8);
    RST = 1'b0;
    #1;
    check("rst_mid_par_bit", 32'(par_bit), 32'd0);
    check("rst_mid_par_en_out", 32'(par_en_out), 32'd0);
    check("rst_mid_err_cnt", 32'(err_cnt), 32'd0);
    rx_par_en = 1'b1; rx_bit = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_mid_no_pulse1", 32'({par_chk_done, par_err}), 32'd0);
    rx_par_en = 1'b0; rx_bit = 1'b0;
    @(negedge CLK);
    check("rst_mid_no_pulse2", 32'({par_chk_done, par_err}), 32'd0);
    m_cnt = 0;
    check("rst_mid_cnt_after", 32'(err_cnt), 32'(m_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
